multi_byte_fetch_decoder: RTL and testbench

- Sequential front end between program-ROM fetch and the Miyamii-4000 execute stage.
- Accepts a stream of instruction bytes over a valid/ready handshake and assembles one- and two-byte instructions.
- Computes jump targets and queues each complete instruction (micro-op) in a parametrised output FIFO for the executor.
- Supports a flush on taken branches. Two-byte opcode classification is parametrised; SRC is correctly single-byte.

---
 rtl/multi_byte_fetch_decoder.sv | 189 ++++++++++++++++++
 tb/tb_multi_byte_fetch_decoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_byte_fetch_decoder.sv
// Multi-byte fetch decoder for the Miyamii-4000 front end.
// Assembles one- and two-byte instructions from a byte stream, computes jump
// targets and queues finished micro-ops in a small FIFO for the executor.
//
// Handshakes (both byte and uop sides): a transfer happens on a rising clock
// edge where valid && ready are both high; valid-side payload must be stable
// while valid is high, and ready never depends on valid in the same cycle.
module multi_byte_fetch_decoder #(
    parameter int          ADDR_W        = 12,
    parameter int          QDEPTH        = 2,
    parameter logic [15:0] TWO_BYTE_MASK = 16'h00B6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [7:0]                   byte_in,
    input  logic [ADDR_W-1:0]            byte_pc,
    input  logic                         byte_valid,
    output logic                         byte_ready,
    output logic                         uop_valid,
    input  logic                         uop_ready,
    output logic [3:0]                   uop_opcode,
    output logic [3:0]                   uop_operand,
    output logic [7:0]                   uop_second,
    output logic                         uop_two_byte,
    output logic [ADDR_W-1:0]            uop_pc,
    output logic [ADDR_W-1:0]            uop_target,
    output logic [$clog2(QDEPTH+1)-1:0]  uop_count,
    output logic                         fsm_state
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(QDEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    localparam logic [0:0] ST_FIRST  = 1'b0;
    localparam logic [0:0] ST_SECOND = 1'b1;

    // Decoder state and the held first byte of a pending two-byte instruction
    logic [0:0]        state_q;
    logic [7:0]        held_byte_q;
    logic [ADDR_W-1:0] held_pc_q;

    // Micro-op storage
    logic [7:0]        mem_first  [QDEPTH];
    logic [7:0]        mem_second [QDEPTH];
    logic              mem_two    [QDEPTH];
    logic [ADDR_W-1:0] mem_pc     [QDEPTH];
    logic [ADDR_W-1:0] mem_target [QDEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;

    // Assembled micro-op about to be pushed
    logic              accept;
    logic              first_is_two;
    logic              push;
    logic              pop;
    logic [7:0]        push_first;
    logic [7:0]        push_second;
    logic              push_two;
    logic [ADDR_W-1:0] push_pc;
    logic [ADDR_W-1:0] push_target;

    // Opcode 2 splits into FIM (even operand, two-byte) and SRC (odd, one-byte)
    function automatic logic is_two_byte(input logic [7:0] b);
        logic r;
        if (b[7:4] == 4'h2) begin
            r = ~b[0];
        end else begin
            r = TWO_BYTE_MASK[b[7:4]];
        end
        return r;
    endfunction

    // Reset term keeps the byte side closed while rst_n is low
    assign byte_ready   = rst_n && !flush && (count_q < FULL_CNT);
    assign accept       = byte_valid && byte_ready;
    assign first_is_two = is_two_byte(byte_in);
    assign push         = accept && ((state_q == ST_SECOND) || !first_is_two);
    assign uop_valid    = (count_q != '0);
    assign pop          = uop_valid && uop_ready && !flush;
    assign uop_count    = count_q;
    assign fsm_state    = state_q[0];

    // Build the micro-op from either the lone first byte or the held pair
    always_comb begin
        push_first  = byte_in;
        push_second = 8'h00;
        push_two    = 1'b0;
        push_pc     = byte_pc;
        push_target = '0;
        if (state_q == ST_SECOND) begin
            push_first  = held_byte_q;
            push_second = byte_in;
            push_two    = 1'b1;
            push_pc     = held_pc_q;
            case (held_byte_q[7:4])
                // JUN / JMS: 12-bit absolute address from operand and second byte
                4'h4, 4'h5: push_target = ADDR_W'({held_byte_q[3:0], byte_in});
                // JCN / ISZ: in-page address, page taken from the second byte's pc
                4'h1, 4'h7: push_target = {byte_pc[ADDR_W-1:8], byte_in};
                default:    push_target = '0;
            endcase
        end
    end

    // Decoder FSM: hold the first byte of a two-byte instruction until its partner arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FIRST;
            held_byte_q <= 8'h00;
            held_pc_q   <= '0;
        end else if (flush) begin
            state_q     <= ST_FIRST;
            held_byte_q <= 8'h00;
            held_pc_q   <= '0;
        end else if (accept) begin
            if (state_q == ST_FIRST) begin
                if (first_is_two) begin
                    state_q     <= ST_SECOND;
                    held_byte_q <= byte_in;
                    held_pc_q   <= byte_pc;
                end
            end else begin
                state_q     <= ST_FIRST;
                held_byte_q <= 8'h00;
                held_pc_q   <= '0;
            end
        end
    end

    // Micro-op FIFO: circular buffer with explicit occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_first[i]  <= 8'h00;
                mem_second[i] <= 8'h00;
                mem_two[i]    <= 1'b0;
                mem_pc[i]     <= '0;
                mem_target[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_first[wr_ptr_q]  <= push_first;
                mem_second[wr_ptr_q] <= push_second;
                mem_two[wr_ptr_q]    <= push_two;
                mem_pc[wr_ptr_q]     <= push_pc;
                mem_target[wr_ptr_q] <= push_target;
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Head outputs read as zero whenever the FIFO is empty
    always_comb begin
        uop_opcode   = 4'h0;
        uop_operand  = 4'h0;
        uop_second   = 8'h00;
        uop_two_byte = 1'b0;
        uop_pc       = '0;
        uop_target   = '0;
        if (uop_valid) begin
            uop_opcode   = mem_first[rd_ptr_q][7:4];
            uop_operand  = mem_first[rd_ptr_q][3:0];
            uop_second   = mem_second[rd_ptr_q];
            uop_two_byte = mem_two[rd_ptr_q];
            uop_pc       = mem_pc[rd_ptr_q];
            uop_target   = mem_target[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_multi_byte_fetch_decoder.sv
// Directed bench for multi_byte_fetch_decoder: per-cycle vector records with
// hand-computed expectations, plus backpressure, flush and mid-instruction reset.
module tb_multi_byte_fetch_decoder;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [7:0]  byte_in;
    logic [11:0] byte_pc;
    logic        byte_valid;
    logic        byte_ready;
    logic        uop_valid;
    logic        uop_ready;
    logic [3:0]  uop_opcode;
    logic [3:0]  uop_operand;
    logic [7:0]  uop_second;
    logic        uop_two_byte;
    logic [11:0] uop_pc;
    logic [11:0] uop_target;
    logic [1:0]  uop_count;
    logic        fsm_state;

    int errors = 0;
    int checks = 0;

    // Scoreboard of expected first bytes, consumed on each observed pop
    logic [7:0] exp_q[$];
    logic       sb_en = 1'b0;

    typedef struct {
        logic        valid;
        logic [7:0]  b;
        logic [11:0] pc;
        logic        rdy;
        logic        fl;
        logic        exp_br;
        logic        exp_v;
        logic [7:0]  exp_first;
        logic [7:0]  exp_sec;
        logic        exp_two;
        logic [11:0] exp_pc;
        logic [11:0] exp_tgt;
        logic [1:0]  exp_cnt;
        logic        exp_st;
    } vec_t;

    vec_t tbl[$];

    multi_byte_fetch_decoder #(
        .ADDR_W(12),
        .QDEPTH(2),
        .TWO_BYTE_MASK(16'h00B6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .byte_in(byte_in),
        .byte_pc(byte_pc),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .uop_valid(uop_valid),
        .uop_ready(uop_ready),
        .uop_opcode(uop_opcode),
        .uop_operand(uop_operand),
        .uop_second(uop_second),
        .uop_two_byte(uop_two_byte),
        .uop_pc(uop_pc),
        .uop_target(uop_target),
        .uop_count(uop_count),
        .fsm_state(fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic valid, input logic [7:0] b, input logic [11:0] pc,
                                input logic rdy, input logic fl, input logic br, input logic v,
                                input logic [7:0] first, input logic [7:0] sec, input logic two,
                                input logic [11:0] upc, input logic [11:0] tgt,
                                input logic [1:0] cnt, input logic st);
        vec_t r;
        r.valid = valid; r.b = b; r.pc = pc; r.rdy = rdy; r.fl = fl;
        r.exp_br = br; r.exp_v = v; r.exp_first = first; r.exp_sec = sec;
        r.exp_two = two; r.exp_pc = upc; r.exp_tgt = tgt; r.exp_cnt = cnt; r.exp_st = st;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check ready mid-cycle, then the registered outputs
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        byte_valid = v.valid;
        byte_in    = v.b;
        byte_pc    = v.pc;
        uop_ready  = v.rdy;
        flush      = v.fl;
        #1;
        chk({tag, " byte_ready"}, 32'(byte_ready), 32'(v.exp_br));
        if (sb_en && uop_valid && uop_ready && !flush) begin
            if (exp_q.size() == 0) begin
                chk({tag, " sb_extra_pop"}, {uop_opcode, uop_operand}, 32'h1FF);
            end else begin
                chk({tag, " sb_order"}, {uop_opcode, uop_operand}, 32'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
        chk({tag, " uop_valid"},    32'(uop_valid),    32'(v.exp_v));
        chk({tag, " uop_first"},    {uop_opcode, uop_operand}, 32'(v.exp_first));
        chk({tag, " uop_second"},   32'(uop_second),   32'(v.exp_sec));
        chk({tag, " uop_two_byte"}, 32'(uop_two_byte), 32'(v.exp_two));
        chk({tag, " uop_pc"},       32'(uop_pc),       32'(v.exp_pc));
        chk({tag, " uop_target"},   32'(uop_target),   32'(v.exp_tgt));
        chk({tag, " uop_count"},    32'(uop_count),    32'(v.exp_cnt));
        chk({tag, " state"},        32'(fsm_state),    32'(v.exp_st));
    endtask

    initial begin
        // Reset
        rst_n = 1'b0; flush = 1'b0; byte_in = 8'h00; byte_pc = 12'h000;
        byte_valid = 1'b0; uop_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset byte_ready", 32'(byte_ready), 32'h0);
        chk("reset uop_valid",  32'(uop_valid),  32'h0);
        chk("reset uop_count",  32'(uop_count),  32'h0);
        chk("reset state",      32'(fsm_state),  32'h0);
        chk("reset uop_pc",     32'(uop_pc),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Main instruction mix, executor always ready
        //          vld  byte   pc      rdy fl   br  v   first  sec    two upc     tgt     cnt st
        tbl.push_back(mk(1, 8'hD5, 12'h000, 1, 0, 1, 1, 8'hD5, 8'h00, 0, 12'h000, 12'h000, 1, 0));
        tbl.push_back(mk(1, 8'hF2, 12'h001, 1, 0, 1, 1, 8'hF2, 8'h00, 0, 12'h001, 12'h000, 1, 0));
        tbl.push_back(mk(1, 8'h40, 12'h010, 1, 0, 1, 0, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 1));
        tbl.push_back(mk(1, 8'h3A, 12'h011, 1, 0, 1, 1, 8'h40, 8'h3A, 1, 12'h010, 12'h03A, 1, 0));
        tbl.push_back(mk(1, 8'h21, 12'h020, 1, 0, 1, 1, 8'h21, 8'h00, 0, 12'h020, 12'h000, 1, 0));
        tbl.push_back(mk(1, 8'h20, 12'h021, 1, 0, 1, 0, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 1));
        tbl.push_back(mk(1, 8'h55, 12'h022, 1, 0, 1, 1, 8'h20, 8'h55, 1, 12'h021, 12'h000, 1, 0));
        tbl.push_back(mk(1, 8'h14, 12'h1FE, 1, 0, 1, 0, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 1));
        tbl.push_back(mk(1, 8'h80, 12'h1FF, 1, 0, 1, 1, 8'h14, 8'h80, 1, 12'h1FE, 12'h180, 1, 0));
        tbl.push_back(mk(1, 8'h72, 12'h2FF, 1, 0, 1, 0, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 1));
        tbl.push_back(mk(1, 8'h10, 12'h300, 1, 0, 1, 1, 8'h72, 8'h10, 1, 12'h2FF, 12'h310, 1, 0));
        tbl.push_back(mk(1, 8'h5A, 12'h030, 1, 0, 1, 0, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 1));
        tbl.push_back(mk(1, 8'hC3, 12'h031, 1, 0, 1, 1, 8'h5A, 8'hC3, 1, 12'h030, 12'hAC3, 1, 0));
        tbl.push_back(mk(1, 8'h34, 12'h032, 1, 0, 1, 1, 8'h34, 8'h00, 0, 12'h032, 12'h000, 1, 0));
        tbl.push_back(mk(0, 8'h00, 12'h000, 1, 0, 1, 0, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Backpressure: fill, stall, then drain with simultaneous push/pop
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);
        sb_en = 1'b1;
        apply(mk(1, 8'hA1, 12'h100, 0, 0, 1, 1, 8'hA1, 8'h00, 0, 12'h100, 12'h000, 1, 0), "bp0");
        apply(mk(1, 8'hA2, 12'h101, 0, 0, 1, 1, 8'hA1, 8'h00, 0, 12'h100, 12'h000, 2, 0), "bp1");
        apply(mk(1, 8'hA3, 12'h102, 0, 0, 0, 1, 8'hA1, 8'h00, 0, 12'h100, 12'h000, 2, 0), "bp2");
        apply(mk(1, 8'hA3, 12'h102, 1, 0, 0, 1, 8'hA2, 8'h00, 0, 12'h101, 12'h000, 1, 0), "bp3");
        apply(mk(1, 8'hA3, 12'h102, 1, 0, 1, 1, 8'hA3, 8'h00, 0, 12'h102, 12'h000, 1, 0), "bp4");
        apply(mk(0, 8'h00, 12'h000, 1, 0, 1, 0, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 0), "bp5");
        sb_en = 1'b0;
        chk("bp scoreboard drained", 32'(exp_q.size()), 32'h0);

        // Flush with a queued uop and a held JMS first byte
        apply(mk(1, 8'hB1, 12'h050, 0, 0, 1, 1, 8'hB1, 8'h00, 0, 12'h050, 12'h000, 1, 0), "fl0");
        apply(mk(1, 8'h50, 12'h051, 0, 0, 1, 1, 8'hB1, 8'h00, 0, 12'h050, 12'h000, 1, 1), "fl1");
        apply(mk(1, 8'h44, 12'h052, 1, 1, 0, 0, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 0), "fl2");
        apply(mk(1, 8'h44, 12'h052, 1, 1, 0, 0, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 0), "fl3");
        apply(mk(1, 8'h00, 12'h060, 0, 0, 1, 1, 8'h00, 8'h00, 0, 12'h060, 12'h000, 1, 0), "fl4");
        apply(mk(0, 8'h00, 12'h000, 1, 0, 1, 0, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 0), "fl5");

        // Reset while waiting for a second byte
        apply(mk(1, 8'h40, 12'h070, 1, 0, 1, 0, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 1), "rs0");
        @(negedge clk);
        byte_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rs state",      32'(fsm_state),  32'h0);
        chk("rs byte_ready", 32'(byte_ready), 32'h0);
        chk("rs uop_valid",  32'(uop_valid),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(1, 8'hE0, 12'h071, 1, 0, 1, 1, 8'hE0, 8'h00, 0, 12'h071, 12'h000, 1, 0), "rs1");
        apply(mk(0, 8'h00, 12'h000, 1, 0, 1, 0, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 0), "rs2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
